// File: rtl/time_keeper_if.sv
// rtl/time_keeper_if.sv - setting controls and time-of-day outputs of time_keeper
// dec_short exists only when TIME_DEC_EN is defined.
interface time_keeper_if;
  logic        setting_enable;
  logic        set_hr_or_min;
  logic        inc_short;
`ifdef TIME_DEC_EN
  logic        dec_short;
`endif
  logic [13:0] hour;
  logic [13:0] minute;
  logic [5:0]  second;
  logic        sec_tick;
  logic        min_tick;
  logic        setting_active;

  modport master (
`ifdef TIME_DEC_EN
    output dec_short,
`endif
    output setting_enable, set_hr_or_min, inc_short,
    input  hour, minute, second, sec_tick, min_tick, setting_active
  );

  modport slave (
`ifdef TIME_DEC_EN
    input  dec_short,
`endif
    input  setting_enable, set_hr_or_min, inc_short,
    output hour, minute, second, sec_tick, min_tick, setting_active
  );
endinterface

// File: rtl/time_keeper.sv
// rtl/time_keeper.sv - 24-hour time-of-day counter with button-driven setting mode
// Optional decrement button enabled by defining TIME_DEC_EN.
module time_keeper #(
  parameter int unsigned CLK_DIV = 50000000,
  parameter int unsigned PRESC_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  time_keeper_if.slave bus
);

  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_DIV - 1);

  typedef enum logic {RUN, SET} state_t;

  state_t             state;
  logic [PRESC_W-1:0] presc_q;
  logic [4:0]         hour_q;
  logic [5:0]         minute_q;
  logic [5:0]         second_q;
  logic               sec_tick_q;
  logic               min_tick_q;
  logic               setting_active_q;
  logic               inc_prev;

  logic tick;
  logic sec_carry;
  logic min_carry;
  logic hr_carry;
  logic inc_rise;
  logic adj_up;
  logic adj_dn;

  // >= rather than == so a corrupted field still wraps on its next step
  assign tick      = (presc_q >= PRESC_MAX);
  assign sec_carry = (second_q >= 6'd59);
  assign min_carry = (minute_q >= 6'd59);
  assign hr_carry  = (hour_q >= 5'd23);
  assign inc_rise  = bus.inc_short & ~inc_prev;

`ifdef TIME_DEC_EN
  logic dec_prev;
  logic dec_rise;

  assign dec_rise = bus.dec_short & ~dec_prev;
  // Opposing presses in one cycle cancel out
  assign adj_up   = inc_rise & ~dec_rise;
  assign adj_dn   = dec_rise & ~inc_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dec_prev <= 1'b0;
    else        dec_prev <= bus.dec_short;
  end
`else
  assign adj_up = inc_rise;
  assign adj_dn = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= RUN;
      presc_q          <= '0;
      hour_q           <= '0;
      minute_q         <= '0;
      second_q         <= '0;
      sec_tick_q       <= 1'b0;
      min_tick_q       <= 1'b0;
      setting_active_q <= 1'b0;
      inc_prev         <= 1'b0;
    end else begin
      inc_prev <= bus.inc_short;
      case (state)
        RUN: begin
          // Carry into minute/hour still lands when this edge also enters SET
          if (tick && sec_carry) begin
            minute_q <= min_carry ? 6'd0 : minute_q + 6'd1;
            if (min_carry) hour_q <= hr_carry ? 5'd0 : hour_q + 5'd1;
          end
          if (bus.setting_enable) begin
            state            <= SET;
            setting_active_q <= 1'b1;
            presc_q          <= '0;
            second_q         <= '0;
            sec_tick_q       <= 1'b0;
            min_tick_q       <= 1'b0;
          end else begin
            presc_q    <= tick ? '0 : presc_q + PRESC_W'(1);
            sec_tick_q <= tick;
            min_tick_q <= tick & sec_carry;
            if (tick) second_q <= sec_carry ? 6'd0 : second_q + 6'd1;
          end
        end
        SET: begin
          presc_q    <= '0;
          second_q   <= '0;
          sec_tick_q <= 1'b0;
          min_tick_q <= 1'b0;
          if (adj_up) begin
            if (bus.set_hr_or_min) minute_q <= min_carry ? 6'd0 : minute_q + 6'd1;
            else                   hour_q   <= hr_carry  ? 5'd0 : hour_q + 5'd1;
          end else if (adj_dn) begin
            if (bus.set_hr_or_min)
              minute_q <= (minute_q == 6'd0 || minute_q > 6'd59) ? 6'd59 : minute_q - 6'd1;
            else
              hour_q   <= (hour_q == 5'd0 || hour_q > 5'd23) ? 5'd23 : hour_q - 5'd1;
          end
          if (!bus.setting_enable) begin
            state            <= RUN;
            setting_active_q <= 1'b0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign bus.hour           = {9'd0, hour_q};
  assign bus.minute         = {8'd0, minute_q};
  assign bus.second         = second_q;
  assign bus.sec_tick       = sec_tick_q;
  assign bus.min_tick       = min_tick_q;
  assign bus.setting_active = setting_active_q;

endmodule

// File: tb/tb_time_keeper.sv
// tb/tb_time_keeper.sv - scoreboard testbench for time_keeper (CLK_DIV=4)
// TIME_DEC_EN adds the decrement scenario.
module tb_time_keeper;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   stray_ticks;

  // {hour, minute, second, min_tick} expected at each sec_tick
  logic [34:0] exp_q[$];

  time_keeper_if tkif ();

  time_keeper #(.CLK_DIV(4), .PRESC_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (tkif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic pulse(input bit is_min, input int n);
    tkif.set_hr_or_min = is_min;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tkif.inc_short = 1'b1;
      if (tkif.sec_tick) stray_ticks++;
      @(negedge clk);
      tkif.inc_short = 1'b0;
      if (tkif.sec_tick) stray_ticks++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    int first;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tkif.hour, tkif.minute, tkif.second, tkif.sec_tick, tkif.min_tick, tkif.setting_active} !== 37'd0) begin
      errors++;
      $display("FAIL reset_state got %0d:%0d:%0d st=%b mt=%b sa=%b want all zero",
               tkif.hour, tkif.minute, tkif.second, tkif.sec_tick, tkif.min_tick, tkif.setting_active);
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({tkif.hour, tkif.minute, tkif.second, tkif.sec_tick, tkif.min_tick, tkif.setting_active} !== 37'd0) begin
      errors++;
      $display("FAIL async_reset got %0d:%0d:%0d st=%b want all zero",
               tkif.hour, tkif.minute, tkif.second, tkif.sec_tick);
    end
    @(negedge clk);
    rst_n = 1'b1;
    first = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (tkif.sec_tick) begin
        first = n;
        break;
      end
    end
    checks++;
    if (first != 4) begin
      errors++;
      $display("FAIL first_tick_after_reset got edge %0d want 4", first);
    end
  endtask

  task automatic test_hour_set();
    stray_ticks = 0;
    tkif.setting_enable = 1'b1;
    pulse(1'b0, 25);
    checks++;
    if (tkif.hour !== 14'd1) begin
      errors++; $display("FAIL hour_set_25 got %0d want 1", tkif.hour);
    end
    checks++;
    if (tkif.minute !== 14'd0 || tkif.second !== 6'd0) begin
      errors++; $display("FAIL hour_set_other got %0d:%0d want 0:0", tkif.minute, tkif.second);
    end
    checks++;
    if (tkif.setting_active !== 1'b1) begin
      errors++; $display("FAIL setting_active got %b want 1", tkif.setting_active);
    end
    checks++;
    if (stray_ticks != 0) begin
      errors++; $display("FAIL tick_in_set got %0d want 0", stray_ticks);
    end
  endtask

  task automatic test_minute_wrap();
    pulse(1'b0, 4);
    pulse(1'b1, 59);
    checks++;
    if (tkif.hour !== 14'd5 || tkif.minute !== 14'd59) begin
      errors++; $display("FAIL preset_0559 got %0d:%0d want 5:59", tkif.hour, tkif.minute);
    end
    pulse(1'b1, 1);
    checks++;
    if (tkif.hour !== 14'd5 || tkif.minute !== 14'd0) begin
      errors++; $display("FAIL minute_wrap got %0d:%0d want 5:0", tkif.hour, tkif.minute);
    end
    tkif.inc_short = 1'b1;
    repeat (20) @(negedge clk);
    tkif.inc_short = 1'b0;
    @(negedge clk);
    checks++;
    if (tkif.hour !== 14'd5 || tkif.minute !== 14'd1) begin
      errors++; $display("FAIL held_button got %0d:%0d want 5:1", tkif.hour, tkif.minute);
    end
  endtask

  task automatic test_rollover();
    int sec_cnt, min_cnt, first;
    logic [34:0] e;
    pulse(1'b0, 18);
    pulse(1'b1, 58);
    checks++;
    if (tkif.hour !== 14'd23 || tkif.minute !== 14'd59) begin
      errors++; $display("FAIL preset_2359 got %0d:%0d want 23:59", tkif.hour, tkif.minute);
    end
    for (int s = 1; s <= 59; s++) exp_q.push_back({14'd23, 14'd59, 6'(s), 1'b0});
    exp_q.push_back({14'd0, 14'd0, 6'd0, 1'b1});
    sec_cnt = 0;
    min_cnt = 0;
    first   = 0;
    tkif.setting_enable = 1'b0;
    for (int n = 0; n < 260; n++) begin
      @(negedge clk);
      if (tkif.min_tick) min_cnt++;
      if (tkif.sec_tick) begin
        sec_cnt++;
        if (sec_cnt == 1) first = n;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rollover_extra_tick got tick %0d want none", sec_cnt);
        end else begin
          e = exp_q.pop_front();
          if ({tkif.hour, tkif.minute, tkif.second, tkif.min_tick} !== e) begin
            errors++;
            $display("FAIL rollover_tick%0d got %0d:%0d:%0d mt=%b want %0d:%0d:%0d mt=%b", sec_cnt,
                     tkif.hour, tkif.minute, tkif.second, tkif.min_tick, e[34:21], e[20:7], e[6:1], e[0]);
          end
        end
        if (sec_cnt == 60) break;
      end
    end
    checks++;
    if (sec_cnt != 60 || exp_q.size() != 0) begin
      errors++; $display("FAIL rollover_tick_count got %0d want 60", sec_cnt);
    end
    checks++;
    if (min_cnt != 1) begin
      errors++; $display("FAIL rollover_min_ticks got %0d want 1", min_cnt);
    end
    checks++;
    if (first != 4) begin
      errors++; $display("FAIL first_tick_after_set got %0d cycles want 4", first);
    end
    exp_q.delete();
  endtask

  task automatic test_ignored_inc();
    pulse(1'b0, 1);
    checks++;
    if (tkif.hour !== 14'd0 || tkif.minute !== 14'd0) begin
      errors++; $display("FAIL inc_in_run got %0d:%0d want 0:0", tkif.hour, tkif.minute);
    end
    tkif.setting_enable = 1'b1;
    tkif.inc_short      = 1'b1;
    repeat (4) @(negedge clk);
    tkif.inc_short = 1'b0;
    @(negedge clk);
    checks++;
    if (tkif.hour !== 14'd0 || tkif.setting_active !== 1'b1) begin
      errors++; $display("FAIL inc_on_entry got hour %0d sa=%b want 0 sa=1", tkif.hour, tkif.setting_active);
    end
  endtask

  task automatic test_carry_on_entry();
    int sec_cnt;
    pulse(1'b0, 10);
    pulse(1'b1, 14);
    sec_cnt = 0;
    tkif.setting_enable = 1'b0;
    for (int n = 0; n < 300 && sec_cnt < 59; n++) begin
      @(negedge clk);
      if (tkif.sec_tick) sec_cnt++;
    end
    checks++;
    if (sec_cnt != 59 || tkif.second !== 6'd59 || tkif.minute !== 14'd14) begin
      errors++;
      $display("FAIL reach_101459 got ticks %0d %0d:%0d want 59 14:59", sec_cnt, tkif.minute, tkif.second);
    end
    repeat (3) @(negedge clk);
    tkif.setting_enable = 1'b1;
    @(negedge clk);
    checks++;
    if (tkif.hour !== 14'd10 || tkif.minute !== 14'd15 || tkif.second !== 6'd0) begin
      errors++;
      $display("FAIL carry_on_entry got %0d:%0d:%0d want 10:15:0", tkif.hour, tkif.minute, tkif.second);
    end
    checks++;
    if (tkif.setting_active !== 1'b1 || tkif.sec_tick !== 1'b0 || tkif.min_tick !== 1'b0) begin
      errors++;
      $display("FAIL entry_flags got sa=%b st=%b mt=%b want 1 0 0", tkif.setting_active, tkif.sec_tick, tkif.min_tick);
    end
  endtask

`ifdef TIME_DEC_EN
  task automatic test_decrement();
    pulse(1'b0, 14);
    pulse(1'b1, 45);
    checks++;
    if (tkif.hour !== 14'd0 || tkif.minute !== 14'd0) begin
      errors++; $display("FAIL preset_0000 got %0d:%0d want 0:0", tkif.hour, tkif.minute);
    end
    tkif.set_hr_or_min = 1'b0;
    @(negedge clk) tkif.dec_short = 1'b1;
    @(negedge clk) tkif.dec_short = 1'b0;
    @(negedge clk);
    checks++;
    if (tkif.hour !== 14'd23) begin
      errors++; $display("FAIL dec_hour_wrap got %0d want 23", tkif.hour);
    end
    tkif.inc_short = 1'b1;
    tkif.dec_short = 1'b1;
    @(negedge clk);
    tkif.inc_short = 1'b0;
    tkif.dec_short = 1'b0;
    @(negedge clk);
    checks++;
    if (tkif.hour !== 14'd23 || tkif.minute !== 14'd0) begin
      errors++; $display("FAIL inc_dec_together got %0d:%0d want 23:0", tkif.hour, tkif.minute);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    stray_ticks = 0;
    rst_n = 1'b0;
    tkif.setting_enable = 1'b0;
    tkif.set_hr_or_min  = 1'b0;
    tkif.inc_short      = 1'b0;
`ifdef TIME_DEC_EN
    tkif.dec_short      = 1'b0;
`endif
    test_reset();
    test_hour_set();
    test_minute_wrap();
    test_rollover();
    test_ignored_inc();
    test_carry_on_entry();
`ifdef TIME_DEC_EN
    test_decrement();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
